// File: rtl/alu_pkg.sv
// Shared opcode constants, opcode legality check and FSM state encoding
// for the ALU execute sequencer.
package alu_pkg;

    localparam int NREG = 8;
    localparam int AW   = 3;
    localparam int DW   = 32;

    // 5-bit ALU select constants; bit 4 is the mode bit and is passed through.
    localparam logic [4:0] OP_MUL    = 5'd0;
    localparam logic [4:0] OP_ADDSUB = 5'd1;
    localparam logic [4:0] OP_LSH    = 5'd2;
    localparam logic [4:0] OP_ASH    = 5'd3;
    localparam logic [4:0] OP_LT     = 5'd5;
    localparam logic [4:0] OP_OR     = 5'd9;
    localparam logic [4:0] OP_NOR    = 5'd11;
    localparam int         OP_MODE_BIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Legality depends only on the function field; the mode bit is ignored.
    function automatic logic op_is_legal(input logic [4:0] op);
        logic legal;
        legal = 1'b0;
        case (op[3:0])
            OP_MUL[3:0], OP_ADDSUB[3:0], OP_LSH[3:0], OP_ASH[3:0],
            OP_LT[3:0], OP_OR[3:0], OP_NOR[3:0]: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8x32 register file: two capture-on-enable read ports feeding the ALU
// operand registers, one combinational debug port, one write port.
// r0 always reads 0 and ignores writes.
module alu_regfile
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_a_i,
    input  logic [AW-1:0] raddr_b_i,
    output logic [DW-1:0] rdata_a_o,
    output logic [DW-1:0] rdata_b_o,
    input  logic [AW-1:0] dbg_addr_i,
    output logic [DW-1:0] dbg_data_o
);

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] rdata_a_q;
    logic [DW-1:0] rdata_b_q;

    // Register storage: cleared on reset, single write port, r0 never written.
    // NOTE: this array is reset on purpose -- all architectural registers must
    // read 0 after reset, so it cannot be left to power-up contents like a RAM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Operand capture: both source registers sampled together when enabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else if (re_i) begin
            rdata_a_q <= regs_q[raddr_a_i];
            rdata_b_q <= regs_q[raddr_b_i];
        end
    end

    assign rdata_a_o  = rdata_a_q;
    assign rdata_b_o  = rdata_b_q;
    assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute sequencer in front of a combinational 32-bit ALU:
// accept -> read operands -> let the ALU settle -> capture/write back ->
// hold the response until the consumer takes it.
module alu_exec_ctrl
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_op,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rs1,
    input  logic [AW-1:0] in_rs2,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [4:0]    alu_sel,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_zero,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic          res_zero,
    output logic          res_err,
    input  logic          pre_we,
    input  logic [AW-1:0] pre_addr,
    input  logic [DW-1:0] pre_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data,
    output logic          zero_flag
);

    state_e        state_q, state_d;
    logic [4:0]    op_q;
    logic [AW-1:0] rd_q, rs1_q, rs2_q;
    logic [4:0]    alu_sel_q;
    logic [DW-1:0] res_data_q;
    logic          res_zero_q, res_err_q, zero_flag_q;

    logic          accept, rf_re, load_err, exec_done;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic and per-state strobes for the datapath.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        rf_re     = 1'b0;
        load_err  = 1'b0;
        exec_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                rf_re = 1'b1;
                if (op_is_legal(op_q)) begin
                    state_d = ST_EXEC;
                end else begin
                    load_err = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_EXEC: begin
                exec_done = 1'b1;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write-port arbitration: writeback in EXEC, preload only while idle.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = pre_addr;
        rf_wdata = pre_data;
        if (exec_done) begin
            rf_we    = 1'b1;
            rf_waddr = rd_q;
            rf_wdata = alu_out;
        end else if ((state_q == ST_IDLE) && pre_we) begin
            rf_we = 1'b1;
        end
    end

    // Instruction latch: fields are captured once at accept so upstream may move on.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q  <= '0;
            rd_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
        end else if (accept) begin
            op_q  <= in_op;
            rd_q  <= in_rd;
            rs1_q <= in_rs1;
            rs2_q <= in_rs2;
        end
    end

    // ALU select register, loaded alongside the operand capture.
    always_ff @(posedge clk) begin
        if (!rst_n)     alu_sel_q <= '0;
        else if (rf_re) alu_sel_q <= op_q;
    end

    // Response and sticky zero flag; illegal ops report an error and skip the flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
            res_err_q   <= 1'b0;
            zero_flag_q <= 1'b0;
        end else if (load_err) begin
            res_data_q <= '0;
            res_zero_q <= 1'b0;
            res_err_q  <= 1'b1;
        end else if (exec_done) begin
            res_data_q  <= alu_out;
            res_zero_q  <= alu_zero;
            res_err_q   <= 1'b0;
            zero_flag_q <= alu_zero;
        end
    end

    alu_regfile u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (rf_we),
        .waddr_i    (rf_waddr),
        .wdata_i    (rf_wdata),
        .re_i       (rf_re),
        .raddr_a_i  (rs1_q),
        .raddr_b_i  (rs2_q),
        .rdata_a_o  (alu_a),
        .rdata_b_o  (alu_b),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign res_valid = (state_q == ST_RESP);
    assign alu_sel   = alu_sel_q;
    assign res_data  = res_data_q;
    assign res_zero  = res_zero_q;
    assign res_err   = res_err_q;
    assign zero_flag = zero_flag_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: a behavioural ALU answers the DUT's operand
// outputs; a register-array model predicts results, latency and side effects.
module tb_alu_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = '0;
    logic [2:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_sel;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        res_zero, res_err;
    logic        pre_we = 1'b0;
    logic [2:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;
    logic [2:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
    logic        zero_flag;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model [8];
    logic        zf_model;

    always #5 clk = ~clk;

    // Behavioural 32-bit ALU; bit 4 selects the variant of each function.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] sel);
        logic [31:0] r;
        r = 32'hDEAD_BEEF;
        case (sel[3:0])
            4'd0:  r = a * b;
            4'd1:  r = sel[4] ? a - b : a + b;
            4'd2:  r = sel[4] ? a >> b[4:0] : a << b[4:0];
            4'd3:  r = $unsigned($signed(a) >>> b[4:0]);
            4'd5:  r = sel[4] ? {31'd0, a < b} : {31'd0, $signed(a) < $signed(b)};
            4'd9:  r = a | b;
            4'd11: r = ~(a | b);
            default: r = 32'hDEAD_BEEF;
        endcase
        return r;
    endfunction

    function automatic bit is_legal(input logic [4:0] op);
        case (op[3:0])
            4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd9, 4'd11: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign alu_out  = alu_fn(alu_a, alu_b, alu_sel);
    assign alu_zero = (alu_out == 32'd0);

    alu_exec_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_zero  (alu_zero),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_zero  (res_zero),
        .res_err   (res_err),
        .pre_we    (pre_we),
        .pre_addr  (pre_addr),
        .pre_data  (pre_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .zero_flag (zero_flag)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One rising edge, then back to the falling edge where we drive and sample.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reg(input logic [2:0] r, input string tag);
        dbg_addr = r;
        #1;
        check(tag, dbg_data, model[r]);
    endtask

    task automatic check_all_regs(input string tag);
        for (int r = 0; r < 8; r++) check_reg(3'(r), tag);
    endtask

    task automatic clear_model();
        for (int r = 0; r < 8; r++) model[r] = '0;
        zf_model = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"},  in_ready,  1);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_data"},  res_data,  0);
        check({tag, "_res_zero"},  res_zero,  0);
        check({tag, "_res_err"},   res_err,   0);
        check({tag, "_alu_a"},     alu_a,     0);
        check({tag, "_alu_b"},     alu_b,     0);
        check({tag, "_alu_sel"},   alu_sel,   0);
        check({tag, "_zero_flag"}, zero_flag, 0);
        check_all_regs({tag, "_reg"});
    endtask

    task automatic preload(input logic [2:0] r, input logic [31:0] d);
        pre_we   = 1'b1;
        pre_addr = r;
        pre_data = d;
        step();
        pre_we = 1'b0;
        if (r != 0) model[r] = d;
    endtask

    // Full instruction: checks latency, operands, response, side effects,
    // and holds the response for `hold` cycles (optionally with noise inputs).
    task automatic issue(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input int hold, input bit junk);
        logic [31:0] a, b, exp;
        bit          legal;
        a     = model[rs1];
        b     = model[rs2];
        legal = is_legal(op);
        exp   = legal ? alu_fn(a, b, op) : 32'd0;

        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        step();                                   // accept edge T
        in_valid = 1'b0;
        pre_we   = 1'b0;
        in_op = 5'($urandom); in_rd = 3'($urandom);
        in_rs1 = 3'($urandom); in_rs2 = 3'($urandom);
        check("res_valid_T", res_valid, 0);
        check("in_ready_busy", in_ready, 0);
        step();                                   // T+1
        check("alu_a", alu_a, a);
        check("alu_b", alu_b, b);
        check("alu_sel", alu_sel, op);
        if (legal) begin
            check("res_valid_T1", res_valid, 0);
            step();                               // T+2
            if (rd != 0) model[rd] = exp;
            zf_model = (exp == 32'd0);
        end
        check("res_valid", res_valid, 1);
        check("res_data", res_data, exp);
        check("res_zero", res_zero, legal && (exp == 32'd0));
        check("res_err", res_err, !legal);
        check("zero_flag", zero_flag, zf_model);
        check_reg(rd, "dbg_rd");

        for (int i = 0; i < hold; i++) begin
            if (junk) begin
                in_valid = 1'b1;
                in_op    = 5'($urandom);
                pre_we   = 1'b1;
                pre_addr = 3'($urandom_range(1, 7));
                pre_data = $urandom;
            end
            step();
            check("hold_valid", res_valid, 1);
            check("hold_data", res_data, exp);
            check("hold_err", res_err, !legal);
            check("hold_zero", res_zero, legal && (exp == 32'd0));
            check("hold_in_ready", in_ready, 0);
        end
        res_ready = 1'b1;
        step();                                   // handshake edge
        res_ready = 1'b0;
        in_valid  = 1'b0;
        pre_we    = 1'b0;
        check("post_res_valid", res_valid, 0);
        check("post_in_ready", in_ready, 1);
        if (junk && hold > 0) check_all_regs("dropped_preload");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "bench did not complete");
    end

    initial begin
        clear_model();
        // Reset
        repeat (2) step();
        rst_n = 1'b1;
        check_reset_state("reset");

        // ADD: 5 + 3 -> r3
        preload(3'd1, 32'd5);
        preload(3'd2, 32'd3);
        issue(5'h01, 3'd3, 3'd1, 3'd2, 0, 1'b0);

        // SUB to zero: 7 - 7 -> r4, sets zero flag
        preload(3'd1, 32'd7);
        preload(3'd2, 32'd7);
        issue(5'h11, 3'd4, 3'd1, 3'd2, 0, 1'b0);

        // Illegal op: error response one cycle early, flag and registers untouched
        issue(5'h04, 3'd5, 3'd1, 3'd2, 1, 1'b0);
        check_all_regs("illegal_no_wb");

        // Preload in the same cycle as an accepted instruction is honoured
        pre_we = 1'b1; pre_addr = 3'd6; pre_data = 32'h0000_0040;
        model[6] = 32'h0000_0040;
        issue(5'h12, 3'd7, 3'd6, 3'd2, 0, 1'b0);  // 0x40 >> 7

        // Reset during EXEC aborts the instruction with no writeback
        preload(3'd1, 32'd9);
        preload(3'd2, 32'd4);
        issue(5'h11, 3'd4, 3'd1, 3'd2, 0, 1'b0);  // 9-4=5, clears zero flag
        preload(3'd3, 32'd4);
        issue(5'h11, 3'd5, 3'd3, 3'd2, 0, 1'b0);  // 4-4=0, sets zero flag
        in_valid = 1'b1; in_op = 5'h01; in_rd = 3'd5; in_rs1 = 3'd1; in_rs2 = 3'd2;
        step();
        in_valid = 1'b0;
        step();                                   // now in EXEC
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        clear_model();
        check_reset_state("rst_exec");

        // Write to r0 is discarded but the response carries the result
        preload(3'd0, 32'hFFFF_FFFF);
        preload(3'd1, 32'h10);
        preload(3'd2, 32'h3);
        issue(5'h02, 3'd0, 3'd1, 3'd2, 0, 1'b0);  // 0x10 << 3 = 0x80

        // Response held for 5 cycles with noise on the input and preload ports
        issue(5'h01, 3'd3, 3'd1, 3'd2, 5, 1'b1);

        // Randomized mix of preloads, legal/illegal ops and backpressure
        for (int n = 0; n < 60; n++) begin
            logic [4:0] op;
            logic [4:0] legal_fn [7];
            legal_fn = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd9, 5'd11};
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 2))
                    0:       preload(3'($urandom), $urandom);
                    1:       preload(3'($urandom), 32'($urandom_range(0, 40)));
                    default: preload(3'($urandom), 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
                endcase
            end
            if ($urandom_range(0, 4) == 0) op = 5'($urandom);
            else op = legal_fn[$urandom_range(0, 6)] | (5'($urandom_range(0, 1)) << 4);
            issue(op, 3'($urandom), 3'($urandom), 3'($urandom),
                  int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end
        check_all_regs("final_regs");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Sequencing stage directly upstream of the 32-bit ALU. It accepts decoded instructions over a valid/ready handshake and reads two source operands from an internal 8x32 register file. It drives the ALU's A, B and select inputs, captures the ALU's combinational result and zero flag, writes the result back, and returns a response. It turns the purely combinational ALU into a multi-cycle execute unit the MCU core can issue to.

## Interface
- NREG, 8: register-file depth; r0 reads 0, writes to r0 discarded
- AW, 3: register address width, log2(NREG)
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  block can accept (high only in IDLE)
- in_op  in  5  ALU select: bit4 = mode, bits3:0 = function
- in_rd, in_rs1, in_rs2  in  AW each  destination / source registers
- alu_a, alu_b  out  32  registered operands to ALU
- alu_sel  out  5  registered select to ALU
- alu_out  in  32  ALU result, combinational from alu_a/alu_b/alu_sel
- alu_zero  in  1  ALU zero flag
- res_valid  out  1  response available
- res_ready  in  1  consumer accepts response
- res_data  out  32  captured result (0 on error)
- res_zero  out  1  captured zero flag
- res_err  out  1  illegal opcode
- pre_we  in  1  preload write enable, honoured only in IDLE
- pre_addr  in  AW, pre_data  in  32  preload address/data
- dbg_addr  in  AW, dbg_data  out  32  combinational register-file read
- zero_flag  out  1  sticky architectural zero flag, updated on each legal writeback

## Operation
- Legal function codes (bits3:0): 0 MUL, 1 ADD_SUB, 2 logical shift, 3 arithmetic shift, 5 compare-less, 9 OR, 11 NOR. Any other value is illegal. Bit4 is passed through unchanged.
- FSM states: IDLE, READ, EXEC, RESP.
- IDLE: in_ready=1. On in_valid, latch op/rd/rs1/rs2 and go to READ. A pre_we in the same cycle as an accepted instruction is still performed.
- READ: alu_a<=rf[rs1], alu_b<=rf[rs2], alu_sel<=op. Legal op -> EXEC. Illegal -> RESP with res_err=1, res_data=0, res_zero=0. No writeback; zero_flag unchanged.
- EXEC: one cycle for the ALU to settle. At its end, res_data<=alu_out, res_zero<=alu_zero, rf[rd]<=alu_out (unless rd=0), zero_flag<=alu_zero. Go to RESP.
- RESP: res_valid=1. Outputs are held stable until res_ready. On res_valid&&res_ready go to IDLE.
- Reading the register file while its write is pending: the write lands at the EXEC->RESP edge, so any later instruction sees the new value. No forwarding is needed.
- pre_we outside IDLE is ignored (dropped, not queued).

## Timing
- Reset (rst_n low at a rising edge): state=IDLE. in_ready=1 after reset release. res_valid=0, res_data=0, res_zero=0, res_err=0, alu_a=0, alu_b=0, alu_sel=0, zero_flag=0, all registers 0.
- Reset mid-operation aborts the instruction. No writeback occurs if reset is asserted in EXEC.
- Latency: accept at edge T; alu_* valid after T+1; result captured and written at T+2; res_valid high from T+2 to the handshake. With res_ready tied high, throughput is one instruction per 4 cycles.
- Illegal op: res_valid high from T+1.
- in_valid while not in IDLE is not accepted. The upstream block must hold the instruction.

## Structure
- Shared package alu_pkg: the 5-bit opcode constants (OP_MUL=0, OP_ADDSUB=1, OP_LSH=2, OP_ASH=3, OP_LT=5, OP_OR=9, OP_NOR=11, OP_MODE_BIT=4), a legal-op check function, and the FSM state encoding.
- One sub-module: alu_regfile (NREG x 32; two synchronous-capture read ports plus the debug port, one write port shared by preload and writeback, r0 hardwired to 0).
- The ALU itself is instantiated by the parent, not inside this block.

## Test plan
- Preload r1=5, r2=3; issue op=1 (ADD_SUB, bit4=0), rd=3. Expect res_data=8, res_zero=0, res_err=0, dbg r3=8, res_valid at T+2.
- Preload r1=r2=7; issue op=0x11 (subtract mode), rd=4. Expect res_data=0, res_zero=1, zero_flag=1, r4=0.
- Issue op=4 (illegal). Expect res_err=1, res_data=0, res_valid at T+1, no register change, zero_flag unchanged.
- Issue with rd=0. Expect a correct res_data, while r0 still reads 0.
- Hold res_ready=0 for 5 cycles in RESP while driving new in_valid and pre_we. Expect outputs stable, in_ready=0, preload dropped, the next instruction accepted only after the handshake.
- Assert rst_n=0 during EXEC. Expect IDLE next cycle, all outputs at reset values, no writeback.
